// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode command sequencer.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_SEND_WAIT,
        ST_POLL,
        ST_POLL_WAIT,
        ST_RESP
    } seq_state_t;

    localparam logic [1:0] SD_CMD_START   = 2'b01;
    localparam logic       SD_CMD_STOP    = 1'b1;
    localparam int         SD_FRAME_BYTES = 6;
    localparam logic [7:0] SD_R1_IDLE     = 8'hFF;

    localparam logic SPI_OP_READ  = 1'b0;
    localparam logic SPI_OP_WRITE = 1'b1;

    // Byte idx of the 48-bit command frame, start bits first, stop bit last.
    function automatic logic [7:0] sd_frame_byte(
        input int          idx,
        input logic [5:0]  index,
        input logic [31:0] arg,
        input logic [6:0]  crc
    );
        logic [7:0] b;
        case (idx)
            0:       b = {SD_CMD_START, index};
            1:       b = arg[31:24];
            2:       b = arg[23:16];
            3:       b = arg[15:8];
            4:       b = arg[7:0];
            5:       b = {crc, SD_CMD_STOP};
            default: b = SD_R1_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_cmd_frame.sv
// Six-byte command frame register, loaded on accept, read out by byte address.
module sd_cmd_frame
    import sd_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [5:0]    cmd_index,
    input  logic [31:0]   cmd_arg,
    input  logic [6:0]    cmd_crc,
    input  logic [AW-1:0] address,
    output logic [7:0]    tx_data
);

    logic [7:0] frame_reg  [SD_FRAME_BYTES];
    logic [7:0] frame_next [SD_FRAME_BYTES];

    for (genvar gi = 0; gi < SD_FRAME_BYTES; gi++) begin : g_byte
        assign frame_next[gi] = sd_frame_byte(gi, cmd_index, cmd_arg, cmd_crc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SD_FRAME_BYTES; i++) frame_reg[i] <= SD_R1_IDLE;
        end else if (load) begin
            for (int i = 0; i < SD_FRAME_BYTES; i++) frame_reg[i] <= frame_next[i];
        end
    end

    // Addresses past the frame read as idle-high MOSI.
    always_comb begin
        tx_data = SD_R1_IDLE;
        for (int i = 0; i < SD_FRAME_BYTES; i++) begin
            if (address == AW'(i)) tx_data = frame_reg[i];
        end
    end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Issues one SD SPI-mode command through spi_controller and polls for its R1 byte.
module sd_cmd_sequencer
    import sd_pkg::*;
#(
    parameter int MEMORY_SIZE_IN_BYTES = 64,
    parameter int POLL_LIMIT           = 8,
    localparam int AW = $clog2(MEMORY_SIZE_IN_BYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [5:0]    cmd_index,
    input  logic [31:0]   cmd_arg,
    input  logic [6:0]    cmd_crc,
    output logic          rsp_valid,
    output logic [7:0]    rsp_r1,
    output logic          rsp_timeout,
    output logic          cs_n,
    output logic          spi_start,
    output logic          spi_op,
    output logic [AW-1:0] spi_size,
    input  logic          spi_done,
    input  logic          spi_wr,
    input  logic [AW-1:0] spi_address,
    input  logic [7:0]    spi_rx_data,
    output logic [7:0]    spi_tx_data
);

    localparam int PCW = $clog2(POLL_LIMIT + 1);

    seq_state_t     state_reg;
    logic [PCW-1:0] poll_cnt_reg;
    logic [7:0]     rx_q_reg;
    logic           accept;
    logic [7:0]     rx_byte;

    assign cmd_ready = (state_reg == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    // A byte strobed in the same cycle as spi_done must drive the decision.
    assign rx_byte   = spi_wr ? spi_rx_data : rx_q_reg;

    sd_cmd_frame #(.AW(AW)) u_frame (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .cmd_crc   (cmd_crc),
        .address   (spi_address),
        .tx_data   (spi_tx_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cs_n         <= 1'b1;
            spi_start    <= 1'b0;
            spi_op       <= SPI_OP_READ;
            spi_size     <= '0;
            rsp_valid    <= 1'b0;
            rsp_r1       <= SD_R1_IDLE;
            rsp_timeout  <= 1'b0;
            poll_cnt_reg <= '0;
            rx_q_reg     <= SD_R1_IDLE;
        end else begin
            spi_start <= 1'b0;
            rsp_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg    <= ST_SEND;
                        poll_cnt_reg <= '0;
                        cs_n         <= 1'b0;
                        spi_start    <= 1'b1;
                        spi_op       <= SPI_OP_WRITE;
                        spi_size     <= AW'(SD_FRAME_BYTES - 1);
                    end
                end
                ST_SEND: state_reg <= ST_SEND_WAIT;
                ST_SEND_WAIT: begin
                    if (spi_done) begin
                        state_reg <= ST_POLL;
                        spi_start <= 1'b1;
                        spi_op    <= SPI_OP_READ;
                        spi_size  <= '0;
                        rx_q_reg  <= SD_R1_IDLE;
                    end
                end
                ST_POLL: state_reg <= ST_POLL_WAIT;
                ST_POLL_WAIT: begin
                    if (spi_wr) rx_q_reg <= spi_rx_data;
                    if (spi_done) begin
                        if (!rx_byte[7]) begin
                            state_reg   <= ST_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_r1      <= rx_byte;
                            rsp_timeout <= 1'b0;
                        end else if (poll_cnt_reg == PCW'(POLL_LIMIT - 1)) begin
                            state_reg   <= ST_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_r1      <= SD_R1_IDLE;
                            rsp_timeout <= 1'b1;
                        end else begin
                            poll_cnt_reg <= poll_cnt_reg + PCW'(1);
                            state_reg    <= ST_POLL;
                            spi_start    <= 1'b1;
                            spi_op       <= SPI_OP_READ;
                            spi_size     <= '0;
                            rx_q_reg     <= SD_R1_IDLE;
                        end
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                    cs_n      <= 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: emulates spi_controller plus an SD card MISO script.
module tb_sd_cmd_sequencer;

    localparam int MEM_BYTES = 64;
    localparam int PL        = 8;
    localparam int AW        = $clog2(MEM_BYTES);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready;
    logic [5:0]    cmd_index;
    logic [31:0]   cmd_arg;
    logic [6:0]    cmd_crc;
    logic          rsp_valid, rsp_timeout, cs_n, spi_start, spi_op;
    logic [7:0]    rsp_r1;
    logic [AW-1:0] spi_size, spi_address;
    logic          spi_done, spi_wr;
    logic [7:0]    spi_rx_data, spi_tx_data;

    always #5 clk = ~clk;

    sd_cmd_sequencer #(.MEMORY_SIZE_IN_BYTES(MEM_BYTES), .POLL_LIMIT(PL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_crc(cmd_crc),
        .rsp_valid(rsp_valid), .rsp_r1(rsp_r1), .rsp_timeout(rsp_timeout),
        .cs_n(cs_n), .spi_start(spi_start), .spi_op(spi_op), .spi_size(spi_size),
        .spi_done(spi_done), .spi_wr(spi_wr), .spi_address(spi_address),
        .spi_rx_data(spi_rx_data), .spi_tx_data(spi_tx_data)
    );

    int vectors = 0;
    int miscompares = 0;
    int txn_no = 0;

    // Expected outputs for the next sample, and their next-cycle values.
    bit            exp_idle, exp_rsp, exp_start, exp_op, exp_to;
    logic [AW-1:0] exp_size;
    logic [7:0]    exp_r1;
    bit            nx_idle, nx_rsp, nx_start, nx_op;
    logic [AW-1:0] nx_size;

    logic [7:0] cur_frame [6];
    logic [7:0] last_frame [6];
    int         cur_reads;
    logic [7:0] cur_r1;
    bit         cur_to;
    logic [7:0] miso_q[$];
    logic [7:0] next_miso[$];
    logic [7:0] mosi_got[$];
    int         reads_got;

    bit x_active, x_op, done_pending;
    int x_size, x_idx, x_wait;

    bit          want_rst, hold_valid, spur_en, churn_arg, rsp_seen, pend_go;
    logic [5:0]  pend_index;
    logic [31:0] pend_arg;
    logic [6:0]  pend_crc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] model_byte(input int i, input logic [5:0] idx,
                                              input logic [31:0] arg, input logic [6:0] crc);
        logic [47:0] f;
        f = {2'b01, idx, arg, crc, 1'b1};
        return f[47 - 8*i -: 8];
    endfunction

    task automatic check_cycle();
        chk("cmd_ready", cmd_ready, exp_idle);
        chk("cs_n", cs_n, exp_idle);
        chk("rsp_valid", rsp_valid, exp_rsp);
        chk("rsp_r1", rsp_r1, exp_r1);
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("spi_start", spi_start, exp_start);
        if (exp_start) begin
            chk("spi_op", spi_op, exp_op);
            chk("spi_size", spi_size, exp_size);
        end
        if (exp_rsp) begin
            rsp_seen = 1;
            chk("mosi_count", mosi_got.size(), 6);
            for (int i = 0; i < 6; i++)
                if (i < mosi_got.size()) chk("mosi_byte", mosi_got[i], cur_frame[i]);
            chk("read_count", reads_got, cur_reads);
            $display("txn %0d: idx=%0d r1=%02h timeout=%0d reads=%0d", txn_no,
                     cur_frame[0][5:0], rsp_r1, rsp_timeout, reads_got);
            txn_no++;
        end
    endtask

    task automatic finish_xfer();
        if (x_op || reads_got < cur_reads) begin
            nx_start = 1; nx_op = 0; nx_size = '0;
        end else begin
            nx_rsp = 1; exp_r1 = cur_r1; exp_to = cur_to;
        end
    endtask

    task automatic step();
        bit accept;
        @(negedge clk);
        check_cycle();
        nx_idle = exp_idle; nx_rsp = 0; nx_start = 0; nx_op = exp_op; nx_size = exp_size;
        spi_wr = 0; spi_done = 0;
        if (want_rst) begin
            rst_n = 0; want_rst = 0;
            x_active = 0; done_pending = 0;
            exp_idle = 1; exp_rsp = 0; exp_start = 0; exp_op = 0; exp_size = '0;
            exp_r1 = 8'hFF; exp_to = 0;
            for (int i = 0; i < 6; i++) last_frame[i] = 8'hFF;
            return;
        end
        rst_n = 1;
        cmd_index = pend_index; cmd_crc = pend_crc;
        if (pend_go) begin cmd_valid = 1; cmd_arg = pend_arg; pend_go = 0; end
        if (!exp_idle && !hold_valid) cmd_valid = 0;
        if (!exp_idle && churn_arg) cmd_arg = $urandom();
        if (exp_rsp) nx_idle = 1;
        accept = exp_idle && cmd_valid;

        if (!x_active && !done_pending && exp_idle) begin
            int a;
            a = $urandom_range(0, MEM_BYTES - 1);
            spi_address = AW'(a);
            #1;
            chk("tx_data_idle", spi_tx_data, (a < 6) ? last_frame[a] : 8'hFF);
            if (spur_en) begin
                spi_done = 1'($urandom_range(0, 1));
                spi_wr = 1'($urandom_range(0, 1));
                spi_rx_data = 8'($urandom_range(0, 127));
            end
        end

        if (accept) begin
            nx_idle = 0; nx_start = 1; nx_op = 1; nx_size = AW'(5);
            for (int i = 0; i < 6; i++) begin
                cur_frame[i] = model_byte(i, cmd_index, cmd_arg, cmd_crc);
                last_frame[i] = cur_frame[i];
            end
            miso_q = next_miso;
            cur_reads = PL; cur_r1 = 8'hFF; cur_to = 1;
            for (int i = PL - 1; i >= 0; i--)
                if (i < miso_q.size() && !miso_q[i][7]) begin
                    cur_reads = i + 1; cur_r1 = miso_q[i]; cur_to = 0;
                end
            mosi_got.delete();
            reads_got = 0;
        end

        if (spi_start && !x_active && !done_pending) begin
            x_active = 1; x_op = spi_op; x_size = int'(spi_size); x_idx = 0;
            x_wait = $urandom_range(0, 2);
        end else if (done_pending) begin
            spi_done = 1; done_pending = 0;
            finish_xfer();
        end else if (x_active) begin
            if (x_wait > 0) x_wait--;
            else begin
                spi_address = AW'(x_idx);
                if (x_op) begin
                    #1;
                    mosi_got.push_back(spi_tx_data);
                end else begin
                    if (miso_q.size() > 0) spi_rx_data = miso_q.pop_front();
                    else spi_rx_data = 8'hFF;
                    spi_wr = 1;
                    reads_got++;
                end
                x_idx++;
                if (x_idx > x_size) begin
                    x_active = 0;
                    if ($urandom_range(0, 1) == 1) begin spi_done = 1; finish_xfer(); end
                    else done_pending = 1;
                end else x_wait = $urandom_range(0, 2);
            end
        end

        exp_idle = nx_idle; exp_rsp = nx_rsp; exp_start = nx_start;
        exp_op = nx_op; exp_size = nx_size;
    endtask

    task automatic wait_rsp(input string name, input int budget);
        int n;
        n = 0;
        rsp_seen = 0;
        while (!rsp_seen && n < budget) begin step(); n++; end
        if (!rsp_seen) begin
            vectors++; miscompares++;
            $display("FAIL %s: no rsp_valid within %0d cycles", name, budget);
            hold_valid = 0; cmd_valid = 0; want_rst = 1;
            step();
        end
    endtask

    task automatic go(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
        pend_index = idx; pend_arg = arg; pend_crc = crc; pend_go = 1;
    endtask

    task automatic chk_frame(input string name, input logic [47:0] lit);
        chk({name, "_count"}, mosi_got.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < mosi_got.size()) chk(name, mosi_got[i], lit[47 - 8*i -: 8]);
    endtask

    initial begin
        int n;
        cmd_valid = 0; cmd_index = 0; cmd_arg = 0; cmd_crc = 0;
        spi_done = 0; spi_wr = 0; spi_address = '0; spi_rx_data = 8'hFF;
        exp_idle = 1; exp_rsp = 0; exp_start = 0; exp_op = 0; exp_size = '0;
        exp_r1 = 8'hFF; exp_to = 0;
        for (int i = 0; i < 6; i++) last_frame[i] = 8'hFF;
        want_rst = 0; hold_valid = 0; spur_en = 0; churn_arg = 0; pend_go = 0;
        pend_index = 0; pend_arg = 0; pend_crc = 0;
        x_active = 0; done_pending = 0; reads_got = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_spi_op", spi_op, 1'b0);
        chk("reset_spi_size", spi_size, '0);
        chk("reset_spi_tx", spi_tx_data, 8'hFF);

        // CMD0: two busy bytes then R1=01
        next_miso = '{8'hFF, 8'hFF, 8'h01};
        go(6'd0, 32'h0, 7'h4A);
        wait_rsp("cmd0", 300);
        chk_frame("cmd0_mosi", 48'h40_00_00_00_00_95);
        chk("cmd0_reads", reads_got, 3);
        chk("cmd0_r1", rsp_r1, 8'h01);
        chk("cmd0_timeout", rsp_timeout, 1'b0);
        repeat (2) step();

        // CMD8: answered on the first read
        next_miso = '{8'h01};
        go(6'd8, 32'h0000_01AA, 7'h43);
        wait_rsp("cmd8", 300);
        chk_frame("cmd8_mosi", 48'h48_00_00_01_AA_87);
        chk("cmd8_reads", reads_got, 1);
        chk("cmd8_r1", rsp_r1, 8'h01);
        repeat (2) step();

        // Card never answers: timeout after POLL_LIMIT reads
        next_miso.delete();
        go(6'd17, 32'h1234_5678, 7'h11);
        wait_rsp("timeout", 300);
        chk("to_reads", reads_got, 8);
        chk("to_r1", rsp_r1, 8'hFF);
        chk("to_flag", rsp_timeout, 1'b1);
        step();
        chk("to_cs_n_after", cs_n, 1'b1);

        // cmd_valid held high with arg churning while busy
        next_miso = '{8'hFF, 8'h05};
        hold_valid = 1; churn_arg = 1;
        go(6'd55, 32'hDEAD_BEEF, 7'h2C);
        wait_rsp("hold1", 300);
        chk_frame("hold1_mosi", {2'b01, 6'd55, 32'hDEAD_BEEF, 7'h2C, 1'b1});
        step();
        hold_valid = 0;
        step();
        chk("hold_second_busy", cmd_ready, 1'b0);
        wait_rsp("hold2", 300);
        churn_arg = 0;
        repeat (2) step();

        // Reset while the write transfer is in flight
        next_miso = '{8'h00};
        go(6'd24, 32'hA5A5_0F0F, 7'h7F);
        n = 0;
        while (!(x_active && x_op && x_idx > 0) && n < 100) begin step(); n++; end
        want_rst = 1;
        step();
        step();
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        next_miso = '{8'hFF, 8'h00};
        go(6'd24, 32'hA5A5_0F0F, 7'h7F);
        wait_rsp("post_rst", 300);
        chk("post_rst_r1", rsp_r1, 8'h00);
        repeat (2) step();

        // Spurious spi_done/spi_wr while idle
        spur_en = 1;
        repeat (20) step();
        spur_en = 0;
        chk("spur_r1_hold", rsp_r1, 8'h00);
        chk("spur_to_hold", rsp_timeout, 1'b0);

        // Randomized commands and card response scripts
        for (int t = 0; t < 40; t++) begin
            int nff;
            nff = $urandom_range(0, PL + 1);
            next_miso.delete();
            for (int k = 0; k < nff; k++) next_miso.push_back(8'h80 | 8'($urandom_range(0, 127)));
            if ($urandom_range(0, 3) != 0) next_miso.push_back(8'($urandom_range(0, 127)));
            churn_arg = 1'($urandom_range(0, 1));
            spur_en = 1'($urandom_range(0, 1));
            go(6'($urandom()), $urandom(), 7'($urandom()));
            wait_rsp("rand", 400);
            repeat ($urandom_range(0, 3)) step();
        end
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
